// File: rtl/dmem_pkg.sv
// Purpose : shared types and derived constants for the lane-addressed data memory.
// Latency : n/a (package only).
// Backpressure: n/a.
// Contents: FSM state enum, LANES/BEATS/IDX_W derivation helpers and the
//           parameter-legality check evaluated at elaboration by lane_data_memory.
package dmem_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    WRITE = 2'd1,
    READ  = 2'd2,
    RESP  = 2'd3
  } state_t;

  function automatic int lanes_f(input int data_w, input int lane_w);
    return data_w / lane_w;
  endfunction

  function automatic int beats_f(input int lanes, input int beat_lanes);
    return lanes / beat_lanes;
  endfunction

  function automatic int idx_w_f(input int depth);
    return (depth > 1) ? $clog2(depth) : 1;
  endfunction

  // Legal when lanes tile the word, beats tile the lanes, and the store is a
  // power of two at least one word deep (modulo wrap relies on IDX_W overflow).
  function automatic bit params_ok(input int data_w, input int lane_w,
                                   input int depth, input int beat_lanes);
    int lanes;
    bit ok;
    ok = (lane_w > 0) && (beat_lanes > 0) && (data_w > 0);
    if (ok) begin
      lanes = data_w / lane_w;
      ok = ((data_w % lane_w) == 0) &&
           ((lanes % beat_lanes) == 0) &&
           (depth >= lanes) && (depth >= 2) &&
           ((depth & (depth - 1)) == 0);
    end
    return ok;
  endfunction

endpackage

// File: rtl/lane_store.sv
// Purpose : DEPTH x LANE_W lane register array with one BEAT_LANES-wide port.
// Latency : writes commit on the rising edge; reads are combinational from the array.
// Backpressure: none; the port accepts a beat every cycle.
// Ports: clk; clear (synchronous, zeroes every lane); start_idx (index of port
//        lane 0, wraps modulo DEPTH); wr_en/wr_data (per-lane write); rd_data.
module lane_store #(
  parameter int LANE_W     = 4,
  parameter int DEPTH      = 16,
  parameter int BEAT_LANES = 4,
  parameter int IDX_W      = 4
) (
  input  logic                         clk,
  input  logic                         clear,
  input  logic [IDX_W-1:0]             start_idx,
  input  logic [BEAT_LANES-1:0]        wr_en,
  input  logic [BEAT_LANES*LANE_W-1:0] wr_data,
  output logic [BEAT_LANES*LANE_W-1:0] rd_data
);

  logic [LANE_W-1:0] mem      [DEPTH];
  logic [IDX_W-1:0]  lane_idx [BEAT_LANES];

  // DEPTH is a power of two, so plain IDX_W-bit addition gives the modulo wrap.
  always_comb begin
    for (int j = 0; j < BEAT_LANES; j++) begin
      lane_idx[j] = start_idx + IDX_W'(j);
    end
  end

  always_comb begin
    rd_data = '0;
    for (int j = 0; j < BEAT_LANES; j++) begin
      rd_data[j*LANE_W +: LANE_W] = mem[lane_idx[j]];
    end
  end

  always_ff @(posedge clk) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem[i] <= '0;
      end
    end else begin
      for (int j = 0; j < BEAT_LANES; j++) begin
        if (wr_en[j]) begin
          mem[lane_idx[j]] <= wr_data[j*LANE_W +: LANE_W];
        end
      end
    end
  end

endmodule

// File: rtl/lane_data_memory.sv
// Purpose : lane-addressed data memory, one DATA_W word as LANES lanes, multi-beat access.
// Latency : write BEATS cycles; read BEATS+1 (ReadValid after BEATS); write+read 2*BEATS+1.
// Backpressure: Ready low while an access is in flight or rst is high; requests then ignored.
// Ports: clk, rst (sync, active-high); Req/Ready handshake with MemWrite/MemRead,
//        ALU_Result (start lane), WriteMemData, LaneMask; ReadMemData/ReadValid/AddrErr out.
// Option: define DMEM_BOUNDS_CHECK_EN to reject ALU_Result >= DEPTH (no write,
//         zero read data, AddrErr pulse); otherwise the address wraps and AddrErr stays 0.
module lane_data_memory
  import dmem_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int LANE_W     = 4,
  parameter int DEPTH      = 16,
  parameter int BEAT_LANES = 4,
  parameter int ADDR_W     = 32,
  localparam int LANES     = lanes_f(DATA_W, LANE_W)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Req,
  output logic              Ready,
  input  logic              MemWrite,
  input  logic              MemRead,
  input  logic [ADDR_W-1:0] ALU_Result,
  input  logic [DATA_W-1:0] WriteMemData,
  input  logic [LANES-1:0]  LaneMask,
  output logic [DATA_W-1:0] ReadMemData,
  output logic              ReadValid,
  output logic              AddrErr
);

  localparam int BEATS = beats_f(LANES, BEAT_LANES);
  localparam int IDX_W = idx_w_f(DEPTH);
  localparam int BW    = BEAT_LANES * LANE_W;
  localparam int BCW   = (BEATS > 1) ? $clog2(BEATS) : 1;
  localparam logic [BCW-1:0] LAST_BEAT = BCW'(BEATS - 1);

  if (!params_ok(DATA_W, LANE_W, DEPTH, BEAT_LANES)) begin : g_bad_params
    $error("lane_data_memory: illegal DATA_W/LANE_W/DEPTH/BEAT_LANES combination");
  end

  state_t              state;
  logic [BCW-1:0]      beat;
  logic [IDX_W-1:0]    cap_idx;
  logic [DATA_W-1:0]   cap_wdata;
  logic [LANES-1:0]    cap_mask;
  logic                cap_read;
  logic                cap_err;
  logic [DATA_W-1:0]   rd_buf;
  logic [DATA_W-1:0]   rd_next;

  logic                accept;
  logic                req_err;
  logic [IDX_W-1:0]    port_idx;
  logic [BEAT_LANES-1:0] port_we;
  logic [BW-1:0]       port_wdata;
  logic [BW-1:0]       port_rdata;

  // Upper address bits only matter to the bounds check.
  logic unused_addr_hi;
  assign unused_addr_hi = ^ALU_Result[ADDR_W-1:IDX_W];

`ifdef DMEM_BOUNDS_CHECK_EN
  assign req_err = (ALU_Result >= ADDR_W'(DEPTH));
`else
  assign req_err = 1'b0;
`endif

  assign Ready  = (state == IDLE) & ~rst;
  assign accept = Req & Ready & (MemWrite | MemRead);

  // Beat b covers word lanes b*BEAT_LANES.. of the captured start index.
  assign port_idx   = cap_idx + IDX_W'(int'(beat) * BEAT_LANES);
  assign port_wdata = cap_wdata[int'(beat)*BW +: BW];
  assign port_we    = (state == WRITE && !cap_err) ?
                      cap_mask[int'(beat)*BEAT_LANES +: BEAT_LANES] : '0;

  // Current beat merged into the partially assembled read word.
  always_comb begin
    rd_next = rd_buf;
    rd_next[int'(beat)*BW +: BW] = port_rdata;
  end

  lane_store #(
    .LANE_W     (LANE_W),
    .DEPTH      (DEPTH),
    .BEAT_LANES (BEAT_LANES),
    .IDX_W      (IDX_W)
  ) u_store (
    .clk       (clk),
    .clear     (rst),
    .start_idx (port_idx),
    .wr_en     (port_we),
    .wr_data   (port_wdata),
    .rd_data   (port_rdata)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      beat        <= '0;
      cap_idx     <= '0;
      cap_wdata   <= '0;
      cap_mask    <= '0;
      cap_read    <= 1'b0;
      cap_err     <= 1'b0;
      rd_buf      <= '0;
      ReadMemData <= '0;
      ReadValid   <= 1'b0;
      AddrErr     <= 1'b0;
    end else begin
      ReadValid <= 1'b0;
      AddrErr   <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            cap_idx   <= ALU_Result[IDX_W-1:0];
            cap_wdata <= WriteMemData;
            cap_mask  <= LaneMask;
            cap_read  <= MemRead;
            cap_err   <= req_err;
            beat      <= '0;
            state     <= MemWrite ? WRITE : READ;
            // Single-beat write: the first beat is already the final one.
            if (BEATS == 1 && MemWrite && !MemRead) begin
              AddrErr <= req_err;
            end
          end
        end
        WRITE: begin
          if (beat == LAST_BEAT) begin
            beat  <= '0;
            state <= cap_read ? READ : IDLE;
          end else begin
            beat <= BCW'(beat + 1'b1);
            // Write-only rejection is flagged for the duration of the final beat.
            if (BCW'(beat + 1'b1) == LAST_BEAT && !cap_read) begin
              AddrErr <= cap_err;
            end
          end
        end
        READ: begin
          rd_buf <= rd_next;
          if (beat == LAST_BEAT) begin
            beat        <= '0;
            ReadMemData <= cap_err ? '0 : rd_next;
            ReadValid   <= 1'b1;
            AddrErr     <= cap_err;
            state       <= RESP;
          end else begin
            beat <= BCW'(beat + 1'b1);
          end
        end
        RESP: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_lane_data_memory.sv
// Purpose : directed self-checking bench for lane_data_memory at default parameters.
// Latency : checks read latency BEATS / 2*BEATS and write completion after BEATS.
// Backpressure: every access waits (bounded) for Ready before driving Req.
module tb_lane_data_memory;

  logic        clk = 1'b0;
  logic        rst;
  logic        Req;
  logic        Ready;
  logic        MemWrite;
  logic        MemRead;
  logic [31:0] ALU_Result;
  logic [31:0] WriteMemData;
  logic [7:0]  LaneMask;
  logic [31:0] ReadMemData;
  logic        ReadValid;
  logic        AddrErr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  lane_data_memory dut (
    .clk          (clk),
    .rst          (rst),
    .Req          (Req),
    .Ready        (Ready),
    .MemWrite     (MemWrite),
    .MemRead      (MemRead),
    .ALU_Result   (ALU_Result),
    .WriteMemData (WriteMemData),
    .LaneMask     (LaneMask),
    .ReadMemData  (ReadMemData),
    .ReadValid    (ReadValid),
    .AddrErr      (AddrErr)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One access: wait for Ready, drive for one edge, scramble inputs afterwards,
  // then check completion latency, read data, AddrErr and the Ready/ReadValid shape.
  task automatic access(input bit w, input bit r, input logic [31:0] addr,
                        input logic [31:0] data, input logic [7:0] mask,
                        input logic [31:0] exp_data, input bit exp_err,
                        input string tag);
    int n;
    bit rdy_low;
    bit err_seen;
    n = 0;
    @(negedge clk);
    while (!Ready && n < 20) begin
      @(negedge clk);
      n++;
    end
    check({tag, " ready_before"}, Ready, 1);
    Req = 1'b1; MemWrite = w; MemRead = r;
    ALU_Result = addr; WriteMemData = data; LaneMask = mask;
    @(posedge clk);
    #1;
    Req = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    ALU_Result = ~addr; WriteMemData = ~data; LaneMask = ~mask;
    n = 0;
    rdy_low = 1'b1;
    err_seen = 1'b0;
    if (r) begin
      @(negedge clk);
      while (!ReadValid && n < 20) begin
        if (Ready) rdy_low = 1'b0;
        @(negedge clk);
        n++;
      end
      if (Ready) rdy_low = 1'b0;
      check({tag, " read_latency"}, n, w ? 4 : 2);
      check({tag, " read_data"}, ReadMemData, exp_data);
      check({tag, " addr_err"}, AddrErr, exp_err);
      check({tag, " ready_low_in_flight"}, rdy_low, 1);
      @(negedge clk);
      check({tag, " valid_pulse"}, ReadValid, 0);
      check({tag, " ready_after"}, Ready, 1);
    end else begin
      @(negedge clk);
      while (!Ready && n < 20) begin
        err_seen |= AddrErr;
        @(negedge clk);
        n++;
      end
      check({tag, " write_latency"}, n, 2);
      check({tag, " write_addr_err"}, err_seen, exp_err);
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    rst = 1'b1; Req = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    ALU_Result = '0; WriteMemData = '0; LaneMask = '0;
    repeat (2) @(posedge clk);
    #1;
    check("ready_in_reset", Ready, 0);
    rst = 1'b0;
    @(negedge clk);
    check("reset_ready", Ready, 1);
    check("reset_valid", ReadValid, 0);
    check("reset_rdata", ReadMemData, 32'h0);
    check("reset_addrerr", AddrErr, 0);

    access(0, 1, 32'd0, 32'h0, 8'h00, 32'h0000_0000, 0, "rd0_after_reset");

    access(1, 0, 32'd3, 32'h8765_4321, 8'hFF, 32'h0, 0, "wr3");
    access(0, 1, 32'd3, 32'h0, 8'h00, 32'h8765_4321, 0, "rd3");
    access(0, 1, 32'd4, 32'h0, 8'h00, 32'h0876_5432, 0, "rd4");

    do_reset();
    access(1, 0, 32'd12, 32'hDEAD_BEEF, 8'hFF, 32'h0, 0, "wr12_wrap");
    access(0, 1, 32'd0, 32'h0, 8'h00, 32'h0000_DEAD, 0, "rd0_wrap");
    access(0, 1, 32'd12, 32'h0, 8'h00, 32'hDEAD_BEEF, 0, "rd12_wrap");

    access(1, 0, 32'd0, 32'hFFFF_FFFF, 8'hFF, 32'h0, 0, "wr0_ones");
    access(1, 0, 32'd0, 32'h0000_0000, 8'h0F, 32'h0, 0, "wr0_masked");
    access(0, 1, 32'd0, 32'h0, 8'h00, 32'hFFFF_0000, 0, "rd0_masked");

    access(1, 1, 32'd8, 32'h1234_5678, 8'hFF, 32'h1234_5678, 0, "rw8_raw");

    // Combined write+read at 8, aborted by reset held over E2 and E3.
    @(negedge clk);
    check("abort ready_before", Ready, 1);
    Req = 1'b1; MemWrite = 1'b1; MemRead = 1'b1;
    ALU_Result = 32'd8; WriteMemData = 32'hCAFE_F00D; LaneMask = 8'hFF;
    @(posedge clk);
    #1;
    Req = 1'b0; MemWrite = 1'b0; MemRead = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("abort ready_low_in_reset", Ready, 0);
    check("abort valid_low", ReadValid, 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort ready_after", Ready, 1);
    check("abort valid_after", ReadValid, 0);
    access(0, 1, 32'd8, 32'h0, 8'h00, 32'h0000_0000, 0, "rd8_after_abort");
    access(0, 1, 32'd0, 32'h0, 8'h00, 32'h0000_0000, 0, "rd0_after_abort");

    access(1, 0, 32'd0, 32'hAAAA_5555, 8'hFF, 32'h0, 0, "wr0_pattern");
`ifdef DMEM_BOUNDS_CHECK_EN
    access(1, 1, 32'd16, 32'h1111_1111, 8'hFF, 32'h0000_0000, 1, "rw16_oob");
    access(1, 0, 32'd16, 32'h2222_2222, 8'hFF, 32'h0, 1, "wr16_oob");
    access(0, 1, 32'd0, 32'h0, 8'h00, 32'hAAAA_5555, 0, "rd0_unchanged");
`else
    access(0, 1, 32'd16, 32'h0, 8'h00, 32'hAAAA_5555, 0, "rd16_truncated");
    access(0, 1, 32'd20, 32'h0, 8'h00, 32'h0000_AAAA, 0, "rd20_truncated");
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/lane_data_memory.md
# lane_data_memory

Parametrised, lane-addressed data memory for the CPU datapath: the successor of the fixed nibble-lane data memory. Each access covers one DATA_W word as LANES consecutive lanes, wrapping modulo DEPTH. The storage port is BEAT_LANES lanes wide, so accesses are multi-beat under a Req/Ready handshake. Adds per-lane write mask, read-after-write on combined requests, synchronous clear and an optional bounds check. Sits between the ALU result/register-file write data and the write-back mux.

## Interface
- DATA_W, 32: word width in bits.
- LANE_W, 4: width of one addressable lane.
- DEPTH, 16: number of lanes stored; must be a power of two and ≥ LANES.
- BEAT_LANES, 4: lanes moved per storage cycle; must divide LANES.
- ADDR_W, 32: address input width.
- Derived: LANES = DATA_W/LANE_W, BEATS = LANES/BEAT_LANES, IDX_W = log2(DEPTH).

Ports:
- clk  in  1  clock; all state changes on rising edge.
- rst  in  1  reset, synchronous, active-high.
- Req  in  1  request strobe.
- Ready  out  1  block can accept a request.
- MemWrite  in  1  request includes a write.
- MemRead  in  1  request includes a read.
- ALU_Result  in  ADDR_W  start lane address.
- WriteMemData  in  DATA_W  write word.
- LaneMask  in  LANES  per-lane write enable; bit k covers WriteMemData[k*LANE_W +: LANE_W].
- ReadMemData  out  DATA_W  read word; held until the next read completes.
- ReadValid  out  1  one-cycle pulse: ReadMemData is new.
- AddrErr  out  1  one-cycle pulse with ReadValid/write completion on a rejected access.

## Operation
- Lane k of an access maps to storage index (ALU_Result[IDX_W-1:0] + k) mod DEPTH. Lane 0 is the least significant.
- A request is accepted on an edge where Req & Ready & (MemWrite | MemRead). Req with neither strobe set is ignored. All request inputs are captured at acceptance; later changes have no effect.
- FSM states: IDLE, WRITE, READ, RESP.
  - IDLE → WRITE when MemWrite is accepted.
  - IDLE → READ when a read only is accepted.
  - WRITE → READ after BEATS beats if MemRead was captured, else → IDLE.
  - READ → RESP after BEATS beats.
  - RESP → IDLE after one cycle.
- Write beat b writes lanes b*BEAT_LANES .. +BEAT_LANES-1. Lanes with a 0 mask bit keep their contents.
- A combined MemWrite+MemRead request performs the write first, so the read returns the new data (read-after-write).
- Ready = (state==IDLE) & ~rst.
- Reset clears all DEPTH lanes to 0 and sets state to IDLE. It clears ReadMemData, ReadValid and AddrErr. Reset asserted mid-access aborts the access; beats already written are erased by the clear.

## Timing
- Acceptance edge is E0. With default parameters, BEATS=2.
- Write only: WRITE during E0–E(BEATS); beat b commits at E(b+1); Ready is high from E(BEATS).
- Read only: READ during E0–E(BEATS); RESP during E(BEATS)–E(BEATS+1) with ReadValid=1; Ready is high from E(BEATS+1).
- Write+read: WRITE during E0–E(BEATS), READ during E(BEATS)–E(2·BEATS), RESP during E(2·BEATS)–E(2·BEATS+1).
- Throughput: one read per BEATS+1 cycles; one write per BEATS cycles.

## Configuration
- DMEM_BOUNDS_CHECK_EN defined: an accepted request with ALU_Result ≥ DEPTH writes nothing.
  - Reads pulse ReadValid with ReadMemData=0.
  - AddrErr pulses in the RESP cycle, or in the final WRITE beat for writes.
  - The FSM timing is unchanged.
- Macro undefined: the address is truncated to IDX_W bits, wrap-around applies, and AddrErr is tied to 0.

## Structure
- Package dmem_pkg holds:
  - the state enum (IDLE/WRITE/READ/RESP);
  - derived-constant functions (LANES, BEATS, IDX_W);
  - the parameter-legality check (elaboration error on violation).
- Sub-module lane_store holds:
  - the DEPTH×LANE_W register array with synchronous clear;
  - one BEAT_LANES-wide port with start index, per-lane write enable and modulo-DEPTH wrap.
- lane_data_memory holds the FSM, the beat counter and read assembly.

## Test plan
- Reset, then read ALU_Result=0 → ReadValid in the cycle after E2, ReadMemData=0x00000000, Ready low during E0–E3.
- Write 0x87654321 at 3 with mask 0xFF, then read 3 → 0x87654321; read 4 → 0x08765432.
- From reset, write 0xDEADBEEF at 12 with mask 0xFF (wraps to lanes 0–3), read 0 → 0x0000DEAD.
- Write 0xFFFFFFFF at 0 with mask 0xFF, then write 0x00000000 at 0 with mask 0x0F, read 0 → 0xFFFF0000.
- Combined write+read at 8 with 0x12345678 → ReadValid in the cycle after E4 with 0x12345678.
  - Repeat the write with rst asserted after E1 → subsequent read 8 returns 0x00000000.
- With DMEM_BOUNDS_CHECK_EN, write+read at 16 → AddrErr with ReadValid and ReadMemData=0; a read at 0 shows memory unchanged.
